inst_queue: RTL and testbench

Dual-port, parametrised instruction queue between fetch and decode in the superscalar core. It accepts up to two entries per cycle from fetch and presents the two oldest entries to a dual-issue decoder, which pops zero, one or two per cycle. It replaces the single-lane FIFO with:

- valid/ready handshaking on both sides,
- show-ahead reads,
- exact occupancy tracking with a usable full state,
- a synchronous flush for branch redirects.

---
 rtl/inst_queue.sv | 108 ++++++++++
 tb/tb_inst_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Dual-lane instruction queue between fetch and decode: two pushes and up to two
// pops per cycle, show-ahead head reads, exact occupancy and synchronous flush.
module inst_queue #(
    parameter int DATA_W   = 128,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [1:0]               wr_valid,
    input  logic [DATA_W-1:0]        wr_data0,
    input  logic [DATA_W-1:0]        wr_data1,
    output logic                     wr_ready,
    output logic [1:0]               rd_valid,
    output logic [DATA_W-1:0]        rd_data0,
    output logic [DATA_W-1:0]        rd_data1,
    input  logic [1:0]               rd_pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Lanes are in-order: lane 1 only counts together with lane 0, so 2'b10 moves nothing.
    function automatic logic [1:0] lane_count(input logic [1:0] req, input logic [1:0] avail);
        logic [1:0] n;
        case (req & avail)
            2'b01:   n = 2'd1;
            2'b11:   n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wp_r;
    logic [AW-1:0]     rp_r;
    logic [CW-1:0]     count_r;

    logic              wr_ready_s;
    logic [1:0]        rd_valid_s;
    logic [1:0]        n_push_s;
    logic [1:0]        n_pop_s;
    logic [AW-1:0]     wp_plus1_s;
    logic [AW-1:0]     rp_plus1_s;

    // Handshake decode from registered occupancy only; a same-cycle pop never frees space.
    always_comb begin
        wr_ready_s = (count_r <= CW'(DEPTH - 2));
        rd_valid_s = {(count_r >= CW'(2)), (count_r >= CW'(1))};
        n_push_s   = lane_count(wr_valid, {2{wr_ready_s}});
        n_pop_s    = lane_count(rd_pop, rd_valid_s);
        wp_plus1_s = wp_r + {{(AW-1){1'b0}}, 1'b1};
        rp_plus1_s = rp_r + {{(AW-1){1'b0}}, 1'b1};
    end

    // Pointer and occupancy state; flush outranks any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_r    <= {AW{1'b0}};
            rp_r    <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            wp_r    <= {AW{1'b0}};
            rp_r    <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            wp_r    <= wp_r + {{(AW-2){1'b0}}, n_push_s};
            rp_r    <= rp_r + {{(AW-2){1'b0}}, n_pop_s};
            count_r <= count_r + {{(CW-2){1'b0}}, n_push_s} - {{(CW-2){1'b0}}, n_pop_s};
        end
    end

    // Entry storage carries no reset; unreachable entries are simply overwritten later.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && (n_push_s != 2'd0)) begin
            mem_r[wp_r] <= wr_data0;
            if (n_push_s == 2'd2) begin
                mem_r[wp_plus1_s] <= wr_data1;
            end
        end
    end

    // Show-ahead head and status decode, masked so invalid lanes read as zero.
    always_comb begin
        wr_ready    = wr_ready_s;
        rd_valid    = rd_valid_s;
        count       = count_r;
        empty       = (count_r == {CW{1'b0}});
        full        = (count_r == CW'(DEPTH));
        almost_full = (count_r >= CW'(AF_LEVEL));
        if (rd_valid_s[0]) begin
            rd_data0 = mem_r[rp_r];
        end else begin
            rd_data0 = {DATA_W{1'b0}};
        end
        if (rd_valid_s[1]) begin
            rd_data1 = mem_r[rp_plus1_s];
        end else begin
            rd_data1 = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: the driver queues accepted writes in order,
// the monitor compares the DUT head, occupancy and flags against that queue.
module tb_inst_queue;

    localparam int DW    = 128;
    localparam int DEPTH = 32;
    localparam int AF    = DEPTH - 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    wr_valid = 2'b00;
    logic [DW-1:0] wr_data0 = '0;
    logic [DW-1:0] wr_data1 = '0;
    logic [1:0]    rd_pop = 2'b00;
    logic          wr_ready;
    logic [1:0]    rd_valid;
    logic [DW-1:0] rd_data0;
    logic [DW-1:0] rd_data1;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          almost_full;

    inst_queue #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_valid(wr_valid), .wr_data0(wr_data0), .wr_data1(wr_data1),
        .wr_ready(wr_ready), .rd_valid(rd_valid),
        .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_pop(rd_pop),
        .count(count), .empty(empty), .full(full), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: compares outputs against the reference queue, then retires popped entries.
    initial begin
        int sz;
        int np;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                sz = exp_q.size();
                check("count", DW'(count), DW'(sz));
                check("empty", DW'(empty), DW'(sz == 0));
                check("full", DW'(full), DW'(sz == DEPTH));
                check("almost_full", DW'(almost_full), DW'(sz >= AF));
                check("wr_ready", DW'(wr_ready), DW'((DEPTH - sz) >= 2));
                check("rd_valid", DW'(rd_valid), DW'({sz >= 2, sz >= 1}));
                check("rd_data0", rd_data0, (sz >= 1) ? exp_q[0] : '0);
                check("rd_data1", rd_data1, (sz >= 2) ? exp_q[1] : '0);
                if (rd_pop == 2'b11 && sz >= 2) np = 2;
                else if (rd_pop[0] && sz >= 1) np = 1;
                else np = 0;
                for (int i = 0; i < np; i++) void'(exp_q.pop_front());
            end
        end
    end

    // One driven cycle; accepted writes join the reference queue after the edge.
    task automatic step(input logic [1:0] wv, input logic [1:0] rp, input logic fl);
        int sz;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        @(negedge clk);
        d0 = rnd();
        d1 = rnd();
        wr_valid = wv;
        wr_data0 = d0;
        wr_data1 = d1;
        rd_pop   = rp;
        flush    = fl;
        sz = exp_q.size();
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
        end else if ((DEPTH - sz) >= 2) begin
            if (wv == 2'b01 || wv == 2'b11) exp_q.push_back(d0);
            if (wv == 2'b11) exp_q.push_back(d1);
        end
        wr_valid = 2'b00;
        rd_pop   = 2'b00;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_wr_ready", DW'(wr_ready), DW'(1));
        check("rst_rd_valid", DW'(rd_valid), DW'(0));
        check("rst_rd_data0", rd_data0, '0);
        check("rst_rd_data1", rd_data1, '0);
        check("rst_count", DW'(count), DW'(0));
        check("rst_flags", DW'({empty, full, almost_full}), DW'(3'b100));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Dual push / dual pop ordering: counts 2,4,2,0
        step(2'b11, 2'b00, 1'b0);
        step(2'b11, 2'b00, 1'b0);
        check("order_cnt4", DW'(count), DW'(4));
        step(2'b00, 2'b11, 1'b0);
        step(2'b00, 2'b11, 1'b0);
        check("order_cnt0", DW'(count), DW'(0));

        // Fill to full, refused pushes, single push refused at DEPTH-1
        repeat (16) step(2'b11, 2'b00, 1'b0);
        check("fill_full", DW'({full, wr_ready, almost_full}), DW'(3'b101));
        check("fill_cnt", DW'(count), DW'(32));
        step(2'b11, 2'b00, 1'b0);
        step(2'b00, 2'b01, 1'b0);
        step(2'b01, 2'b00, 1'b0);
        check("dm1_refuse", DW'(count), DW'(31));
        step(2'b10, 2'b10, 1'b0);

        // Simultaneous traffic and over-pop
        step(2'b00, 2'b00, 1'b1);
        step(2'b01, 2'b00, 1'b0);
        step(2'b11, 2'b11, 1'b0);
        check("simul_cnt", DW'(count), DW'(2));
        step(2'b00, 2'b01, 1'b0);
        step(2'b00, 2'b11, 1'b0);
        check("overpop_cnt", DW'(count), DW'(0));

        // Wrap-around with odd head so rd_data0/rd_data1 straddle 31 -> 0
        step(2'b00, 2'b00, 1'b1);
        step(2'b01, 2'b00, 1'b0);
        step(2'b11, 2'b01, 1'b0);
        step(2'b01, 2'b00, 1'b0);
        repeat (40) step(2'b11, 2'b11, 1'b0);
        check("wrap_cnt", DW'(count), DW'(3));

        // Flush priority at count 10
        step(2'b00, 2'b00, 1'b1);
        repeat (5) step(2'b11, 2'b00, 1'b0);
        step(2'b11, 2'b11, 1'b1);
        check("flush_state", DW'({count, rd_valid, wr_ready}), DW'({6'd0, 2'b00, 1'b1}));
        check("flush_data", rd_data0 | rd_data1, '0);
        step(2'b11, 2'b00, 1'b0);
        step(2'b00, 2'b11, 1'b0);

        // Randomised traffic, biased toward filling, with occasional flushes
        for (int i = 0; i < 400; i++) begin
            logic [1:0] wv;
            logic [1:0] rp;
            wv = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
            rp = 2'($urandom_range(0, 3));
            step(wv, rp, 1'($urandom_range(0, 40) == 0));
            if (i == 200) do_reset();
        end

        do_reset();
        step(2'b00, 2'b00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
